// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus widths, timeout-timer width and the
// native-slave FSM state encoding.
// No ports (package).
package wb_pkg;

    localparam int unsigned WB_ADR_W = 32;
    localparam int unsigned WB_DAT_W = 32;
    localparam int unsigned WB_SEL_W = WB_DAT_W / 8;

    // Width of the native-side wait timer.
    localparam int unsigned TIMER_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } wb_state_e;

endpackage

// File: rtl/wb_native_slave_if.sv
// Bundle of the Wishbone slave-side signals and the native memory request
// signals handled by wb_native_slave.
// Modports:
//   slave  - the bridge: takes Wishbone requests, issues native requests
//   master - the environment: Wishbone master plus native memory responder
interface wb_native_slave_if;
    import wb_pkg::*;

    logic [WB_ADR_W-1:0] wbs_adr_i;
    logic [WB_DAT_W-1:0] wbs_dat_i;
    logic [WB_SEL_W-1:0] wbs_sel_i;
    logic                wbs_we_i;
    logic                wbs_stb_i;
    logic                wbs_cyc_i;
    logic [WB_DAT_W-1:0] wbs_dat_o;
    logic                wbs_ack_o;
    logic                wbs_err_o;

    logic                mem_valid;
    logic [WB_ADR_W-1:0] mem_addr;
    logic [WB_DAT_W-1:0] mem_wdata;
    logic [WB_SEL_W-1:0] mem_wstrb;
    logic                mem_ready;
    logic [WB_DAT_W-1:0] mem_rdata;

    modport slave (
        input  wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_stb_i, wbs_cyc_i,
        output wbs_dat_o, wbs_ack_o, wbs_err_o,
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport master (
        output wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_stb_i, wbs_cyc_i,
        input  wbs_dat_o, wbs_ack_o, wbs_err_o,
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/wb_timeout_ctr.sv
// Native-side wait timer for wb_native_slave.
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset
//   clear   - synchronous clear to zero (has priority over enable)
//   enable  - count up by one this cycle
//   expired - count has reached LIMIT-1
module wb_timeout_ctr
    import wb_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(LIMIT - 1);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TIMER_W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/wb_native_slave.sv
// Wishbone classic slave to native valid/ready memory bridge.
// One outstanding request; terminates with ack on native completion or
// err when the native side does not answer within TIMEOUT_CYCLES.
// Ports:
//   wb_clk_i  - clock, rising edge
//   wb_rst_ni - asynchronous active-low reset
//   bus       - wb_native_slave_if.slave: Wishbone slave signals
//               (wbs_*) and native request/response signals (mem_*)
module wb_native_slave
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    wb_native_slave_if.slave      bus
);

    wb_state_e           state_q, state_d;
    logic                valid_q, valid_d;
    logic [WB_ADR_W-1:0] addr_q, addr_d;
    logic [WB_DAT_W-1:0] wdata_q, wdata_d;
    logic [WB_SEL_W-1:0] wstrb_q, wstrb_d;
    logic                is_read_q, is_read_d;
    logic [WB_DAT_W-1:0] dat_q, dat_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;

    logic tmr_clear;
    logic tmr_en;
    logic tmr_expired;

    wb_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_ni),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= ST_IDLE;
            valid_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            is_read_q <= 1'b0;
            dat_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            is_read_q <= is_read_d;
            dat_q     <= dat_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        is_read_d = is_read_q;
        dat_d     = dat_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
                    addr_d    = bus.wbs_adr_i;
                    wdata_d   = bus.wbs_dat_i;
                    // A write with no byte selects degrades to a read whose
                    // data is dropped, so is_read follows we, not wstrb.
                    wstrb_d   = bus.wbs_we_i ? bus.wbs_sel_i : '0;
                    is_read_d = !bus.wbs_we_i;
                    valid_d   = 1'b1;
                    tmr_clear = 1'b1;
                    state_d   = ST_REQ;
                end
            end

            ST_REQ: begin
                // Completion beats timeout; an abandoned cycle that
                // completes in the same cycle goes straight back to idle.
                if (bus.mem_ready) begin
                    valid_d = 1'b0;
                    if (bus.wbs_cyc_i) begin
                        if (is_read_q) begin
                            dat_d = bus.mem_rdata;
                        end
                        ack_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (tmr_expired) begin
                    valid_d = 1'b0;
                    if (bus.wbs_cyc_i) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    tmr_en = 1'b1;
                    if (!bus.wbs_cyc_i) begin
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                // Master has gone; keep the native request alive until it
                // finishes so the memory side is never cut mid-transfer.
                if (bus.mem_ready || tmr_expired) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.mem_valid = valid_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wstrb = wstrb_q;
    assign bus.wbs_dat_o = dat_q;
    assign bus.wbs_ack_o = ack_q;
    assign bus.wbs_err_o = err_q;

endmodule

// File: tb/tb_wb_native_slave.sv
// Self-checking bench for wb_native_slave: directed vector table, hand
// sequences for abandoned cycles and reset, and randomized transactions
// checked against a transaction-level outcome model.
module tb_wb_native_slave;

    localparam int unsigned TMO = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    wb_native_slave_if bus();

    wb_native_slave #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        ack;
        logic        err;
        int unsigned edges;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        stable;
        logic        post_clean;
        logic        valid_after;
        logic [31:0] dat;
    } res_t;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int unsigned delay;
        logic [31:0] rdata;
        logic        ack;
        logic        err;
        logic [3:0]  wstrb;
        logic [31:0] exp_dat;
        int unsigned edges;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One Wishbone transaction; the native responder raises mem_ready in
    // REQ cycle number 'delay' (0 = first cycle mem_valid is seen high).
    task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int unsigned delay,
                          input logic [31:0] rdata, output res_t r);
        r.ack = 1'b0; r.err = 1'b0; r.edges = 0; r.addr = '0; r.wdata = '0;
        r.wstrb = '0; r.stable = 1'b1; r.post_clean = 1'b1; r.valid_after = 1'b1;
        r.dat = '0;
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
        bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;  bus.wbs_sel_i = sel;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        r.edges = 1;
        r.addr  = bus.mem_addr;
        r.wdata = bus.mem_wdata;
        r.wstrb = bus.mem_wstrb;
        if (bus.mem_valid !== 1'b1) r.stable = 1'b0;
        while (!(r.ack || r.err) && r.edges < 40) begin
            if (r.edges - 1 == delay) begin
                bus.mem_ready = 1'b1; bus.mem_rdata = rdata;
            end else begin
                bus.mem_ready = 1'b0; bus.mem_rdata = $urandom;
            end
            @(posedge clk);
            r.edges++;
            @(negedge clk);
            bus.mem_ready = 1'b0;
            if (bus.wbs_ack_o || bus.wbs_err_o) begin
                r.ack = bus.wbs_ack_o;
                r.err = bus.wbs_err_o;
                r.valid_after = bus.mem_valid;
            end else if (bus.mem_valid !== 1'b1 || bus.mem_addr !== r.addr ||
                         bus.mem_wdata !== r.wdata || bus.mem_wstrb !== r.wstrb) begin
                r.stable = 1'b0;
            end
        end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (bus.wbs_ack_o || bus.wbs_err_o) r.post_clean = 1'b0;
        r.dat = bus.wbs_dat_o;
    endtask

    task automatic compare(input string tag, input res_t r, input logic ack, input logic err,
                           input logic [3:0] wstrb, input logic [31:0] adr,
                           input logic [31:0] wdata, input logic [31:0] dat,
                           input int unsigned edges);
        check({tag, " ack"},        32'(r.ack),         32'(ack));
        check({tag, " err"},        32'(r.err),         32'(err));
        check({tag, " wstrb"},      32'(r.wstrb),       32'(wstrb));
        check({tag, " addr"},       r.addr,             adr);
        check({tag, " wdata"},      r.wdata,            wdata);
        check({tag, " stable"},     32'(r.stable),      32'd1);
        check({tag, " pulse1"},     32'(r.post_clean),  32'd1);
        check({tag, " valid_drop"}, 32'(r.valid_after), 32'd0);
        check({tag, " dat_o"},      r.dat,              dat);
        check({tag, " latency"},    r.edges,            edges);
    endtask

    // Transaction-level outcome: completion within the wait limit acks
    // (ready wins on the last allowed cycle), otherwise err after TMO.
    function automatic void model(input logic we, input logic [3:0] sel, input int unsigned delay,
                                  input logic [31:0] rdata, inout logic [31:0] dat_state,
                                  output logic ack, output logic err,
                                  output logic [3:0] wstrb, output int unsigned edges);
        wstrb = we ? sel : 4'h0;
        if (delay < TMO) begin
            ack = 1'b1; err = 1'b0; edges = delay + 2;
            if (!we) dat_state = rdata;
        end else begin
            ack = 1'b0; err = 1'b1; edges = TMO + 1;
        end
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[8];
        res_t        r;
        logic [31:0] model_dat;
        logic        e_ack, e_err;
        logic [3:0]  e_wstrb;
        int unsigned e_edges;
        int unsigned cnt;
        logic        saw_term;

        //          we    adr          dat           sel  dly  rdata         ack   err   wstrb exp_dat       edges
        vecs[0] = '{1'b0, 32'h100,     32'h0,        4'hF, 3,   32'hDEADBEEF, 1'b1, 1'b0, 4'h0, 32'hDEADBEEF, 5};
        vecs[1] = '{1'b1, 32'h204,     32'h12345678, 4'hC, 2,   32'h99999999, 1'b1, 1'b0, 4'hC, 32'hDEADBEEF, 4};
        vecs[2] = '{1'b0, 32'h300,     32'h0,        4'hF, 255, 32'h0,        1'b0, 1'b1, 4'h0, 32'hDEADBEEF, 9};
        vecs[3] = '{1'b0, 32'h304,     32'h0,        4'h3, 7,   32'hCAFEF00D, 1'b1, 1'b0, 4'h0, 32'hCAFEF00D, 9};
        vecs[4] = '{1'b1, 32'h308,     32'hAAAA5555, 4'h0, 0,   32'h11111111, 1'b1, 1'b0, 4'h0, 32'hCAFEF00D, 2};
        vecs[5] = '{1'b0, 32'h30C,     32'h0,        4'hF, 0,   32'h0BADC0DE, 1'b1, 1'b0, 4'h0, 32'h0BADC0DE, 2};
        vecs[6] = '{1'b1, 32'h310,     32'hFEEDFACE, 4'hF, 8,   32'h22222222, 1'b0, 1'b1, 4'hF, 32'h0BADC0DE, 9};
        vecs[7] = '{1'b0, 32'h314,     32'h0,        4'h1, 1,   32'h12340000, 1'b1, 1'b0, 4'h0, 32'h12340000, 3};

        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        bus.wbs_adr_i = '0;   bus.wbs_dat_i = '0;   bus.wbs_sel_i = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst mem_valid", 32'(bus.mem_valid), 32'd0);
        check("rst mem_addr",  bus.mem_addr,       32'd0);
        check("rst mem_wdata", bus.mem_wdata,      32'd0);
        check("rst mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
        check("rst dat_o",     bus.wbs_dat_o,      32'd0);
        check("rst ack",       32'(bus.wbs_ack_o), 32'd0);
        check("rst err",       32'(bus.wbs_err_o), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            do_txn(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].delay,
                   vecs[i].rdata, r);
            compare($sformatf("vec%0d", i), r, vecs[i].ack, vecs[i].err, vecs[i].wstrb,
                    vecs[i].adr, vecs[i].dat, vecs[i].exp_dat, vecs[i].edges);
        end

        // Cycle abandoned in REQ, native completes two cycles later
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_adr_i = 32'h400;
        @(posedge clk);
        @(negedge clk);
        check("drop valid_up", 32'(bus.mem_valid), 32'd1);
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        saw_term = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.wbs_ack_o || bus.wbs_err_o || !bus.mem_valid) saw_term = 1'b1;
        end
        check("drop held", 32'(saw_term), 32'd0);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h77777777;
        @(posedge clk);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        check("drop valid_low", 32'(bus.mem_valid), 32'd0);
        saw_term = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.wbs_ack_o || bus.wbs_err_o) saw_term = 1'b1;
            @(negedge clk);
        end
        check("drop no_term", 32'(saw_term), 32'd0);
        check("drop dat_keep", bus.wbs_dat_o, 32'h12340000);
        do_txn(1'b0, 32'h404, 32'h0, 4'hF, 1, 32'hA5A5A5A5, r);
        compare("after_drop", r, 1'b1, 1'b0, 4'h0, 32'h404, 32'h0, 32'hA5A5A5A5, 3);

        // Cycle abandoned in REQ, native never answers: drains on timeout
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_adr_i = 32'h500;
        @(posedge clk);
        @(negedge clk);
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        cnt = 0;
        saw_term = 1'b0;
        while (bus.mem_valid && cnt < 30) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (bus.wbs_ack_o || bus.wbs_err_o) saw_term = 1'b1;
        end
        check("drain tmo_cycles", cnt, TMO);
        repeat (2) begin
            @(negedge clk);
            if (bus.wbs_ack_o || bus.wbs_err_o) saw_term = 1'b1;
        end
        check("drain no_term", 32'(saw_term), 32'd0);

        // Reset asserted mid-REQ
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
        bus.wbs_adr_i = 32'h600; bus.wbs_dat_i = 32'hCCCCCCCC; bus.wbs_sel_i = 4'hF;
        @(posedge clk);
        @(negedge clk);
        check("midrst valid_up", 32'(bus.mem_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst mem_valid", 32'(bus.mem_valid), 32'd0);
        check("midrst mem_addr",  bus.mem_addr,       32'd0);
        check("midrst mem_wdata", bus.mem_wdata,      32'd0);
        check("midrst mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
        check("midrst dat_o",     bus.wbs_dat_o,      32'd0);
        check("midrst ack",       32'(bus.wbs_ack_o), 32'd0);
        check("midrst err",       32'(bus.wbs_err_o), 32'd0);
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        saw_term = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.wbs_ack_o || bus.wbs_err_o || bus.mem_valid) saw_term = 1'b1;
        end
        check("midrst quiet", 32'(saw_term), 32'd0);
        do_txn(1'b0, 32'h700, 32'h0, 4'hF, 1, 32'h55AA55AA, r);
        compare("b2b0", r, 1'b1, 1'b0, 4'h0, 32'h700, 32'h0, 32'h55AA55AA, 3);
        do_txn(1'b0, 32'h704, 32'h0, 4'hF, 0, 32'h600DF00D, r);
        compare("b2b1", r, 1'b1, 1'b0, 4'h0, 32'h704, 32'h0, 32'h600DF00D, 2);

        // Randomized transactions against the outcome model
        model_dat = 32'h600DF00D;
        for (int i = 0; i < 40; i++) begin
            logic        we;
            logic [3:0]  sel;
            logic [31:0] adr, dat, rdata;
            int unsigned dly;
            we    = 1'($urandom_range(0, 1));
            sel   = 4'($urandom);
            adr   = $urandom;
            dat   = $urandom;
            rdata = $urandom;
            dly   = $urandom_range(0, 10);
            model(we, sel, dly, rdata, model_dat, e_ack, e_err, e_wstrb, e_edges);
            do_txn(we, adr, dat, sel, dly, rdata, r);
            compare($sformatf("rnd%0d", i), r, e_ack, e_err, e_wstrb, adr, dat, model_dat, e_edges);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_native_slave.md
WB_NATIVE_SLAVE -- requirements
Module: wb_native_slave

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, native-side wait limit in cycles (1..65535).
REQ-002 SHALL have port wb_clk_i  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port wb_rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port wbs_adr_i  input  32  Wishbone address.
REQ-005 SHALL have port wbs_dat_i  input  32  Wishbone write data.
REQ-006 SHALL have port wbs_sel_i  input  4  byte selects.
REQ-007 SHALL have port wbs_we_i  input  1  write enable.
REQ-008 SHALL have port wbs_stb_i  input  1  strobe.
REQ-009 SHALL have port wbs_cyc_i  input  1  cycle valid.
REQ-010 SHALL have port wbs_dat_o  output  32  read data, registered.
REQ-011 SHALL have port wbs_ack_o  output  1  normal termination, registered.
REQ-012 SHALL have port wbs_err_o  output  1  error termination (timeout), registered.
REQ-013 SHALL have port mem_valid  output  1  native request valid.
REQ-014 SHALL have port mem_addr  output  32  native address.
REQ-015 SHALL have port mem_wdata  output  32  native write data.
REQ-016 SHALL have port mem_wstrb  output  4  native write strobes; 0 = read.
REQ-017 SHALL have port mem_ready  input  1  native completion.
REQ-018 SHALL have port mem_rdata  input  32  native read data, valid with mem_ready.

Function
REQ-019 SHALL implement FSM states IDLE, REQ, DONE, DRAIN.
REQ-020 IDLE: on wbs_cyc_i & wbs_stb_i, SHALL register mem_addr=wbs_adr_i, mem_wdata=wbs_dat_i, mem_wstrb=(wbs_we_i ? wbs_sel_i : 0), set mem_valid=1, clear timer, go REQ.
REQ-021 Write with wbs_sel_i=0 SHALL be issued as mem_wstrb=0 (read); read data then discarded (no write occurs).
REQ-022 mem_valid, mem_addr, mem_wdata, mem_wstrb SHALL stay stable while in REQ until mem_ready sampled high.
REQ-023 REQ with mem_ready=1: SHALL capture wbs_dat_o=mem_rdata (reads only; writes leave wbs_dat_o unchanged), clear mem_valid, pulse wbs_ack_o next cycle, go DONE.
REQ-024 REQ: 16-bit timer SHALL increment each cycle without mem_ready; at timer==TIMEOUT_CYCLES-1 without mem_ready, SHALL clear mem_valid, assert wbs_err_o, go DONE.
REQ-025 mem_ready and timeout in same cycle: mem_ready SHALL win (ack, not err).
REQ-026 DONE: wbs_ack_o/wbs_err_o SHALL be high exactly one cycle, then cleared; go IDLE; next request accepted earliest the cycle after DONE.
REQ-027 Latency: strobe sampled at edge N -> mem_valid high after N; mem_ready sampled at edge M -> ack high after M, one cycle; minimum strobe-to-ack 2 cycles.
REQ-028 wbs_cyc_i dropped while in REQ: SHALL go DRAIN, keep mem_valid until mem_ready or timeout, then return IDLE with no ack/err.
REQ-029 wbs_ack_o and wbs_err_o SHALL never be high together; SHALL be low whenever state is not DONE.
REQ-030 mem_ready outside REQ/DRAIN SHALL be ignored.

Reset
REQ-031 Asserting wb_rst_ni low SHALL immediately force state=IDLE, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, wbs_dat_o=0, wbs_ack_o=0, wbs_err_o=0, timer=0.
REQ-032 Reset mid-transaction SHALL abandon it without ack/err; release deasserts synchronously to wb_clk_i via the FSM flops only.

Structure
REQ-033 FSM state encodings (IDLE=0, REQ=1, DONE=2, DRAIN=3) and timer width SHALL live in shared package wb_pkg alongside existing Wishbone constants.
REQ-034 Timeout counter SHALL be a sub-module wb_timeout_ctr (clear, enable, expired output); rest flat.

Verification
REQ-035 Read: adr=0x100, we=0, mem_ready 3 cycles after mem_valid with rdata=0xDEADBEEF -> mem_wstrb=0, one-cycle ack, wbs_dat_o=0xDEADBEEF.
REQ-036 Write: adr=0x204, dat=0x12345678, sel=0xC -> mem_wstrb=0xC, mem_wdata=0x12345678 stable until ready, one-cycle ack, no err.
REQ-037 Timeout: TIMEOUT_CYCLES=8, mem_ready never -> mem_valid drops, wbs_err_o high one cycle 8 cycles after mem_valid, no ack.
REQ-038 Same-cycle ready and timeout -> ack only; err stays 0.
REQ-039 cyc dropped in REQ, mem_ready 2 cycles later -> no ack/err, FSM IDLE, next read completes normally.
REQ-040 Reset asserted mid-REQ -> all outputs zero immediately; after release, back-to-back reads each ack exactly once.
